// File: rtl/main_memory_responder.sv
// main_memory_responder: block-wide memory model with a fixed access latency.
//
// A request (read or write) is accepted while idle, the address/data/op are
// latched, and the operation completes exactly LATENCY clock edges later.
// Requests seen while busy are dropped, not queued. Read+write in the same
// cycle is treated as a write.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to add the err_mem output. A
// request whose address is not block aligned (addr[1:0] != 0) then still runs
// the full latency but completes with an err_mem pulse instead of touching
// the array or the read data.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   addr_mem         block request address
//   read_mem_enable  block read request
//   write_mem_enable block write request (wins over a simultaneous read)
//   wdata_mem        write block, byte 0 in bits [7:0]
//   rdata_mem        registered read block, changes only on read completion
//   ready_memory     registered, high when a request can be accepted
//   rvalid_mem       one-cycle pulse marking rdata_mem valid
//   err_mem          one-cycle misalignment pulse (MEM_ALIGN_CHECK_EN only)
module main_memory_responder #(
  parameter int unsigned AWIDTH       = 16,
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned BLOCKSIZE    = 4,
  parameter int unsigned DEPTH_BLOCKS = 256,
  parameter int unsigned LATENCY      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [AWIDTH-1:0]             addr_mem,
  input  logic                          read_mem_enable,
  input  logic                          write_mem_enable,
  input  logic [DATAWIDTH*BLOCKSIZE-1:0] wdata_mem,
  output logic [DATAWIDTH*BLOCKSIZE-1:0] rdata_mem,
  output logic                          ready_memory,
  output logic                          rvalid_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                          err_mem
`endif
);

  localparam int unsigned BlockW = DATAWIDTH * BLOCKSIZE;
  localparam int unsigned IdxW   = $clog2(DEPTH_BLOCKS);
  // Keep the counter at least one bit wide so LATENCY == 1 still elaborates.
  localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BlockW-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              ready_d;
  logic              rvalid_d;
  logic [BlockW-1:0] rdata_d;
  logic              mem_we;

  logic [BlockW-1:0] mem [DEPTH_BLOCKS];

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic err_d;
  logic unused_addr;
  assign unused_addr = ^addr_mem[AWIDTH-1:IdxW+2];
`else
  // Low and high address bits do not select a block in this build.
  logic unused_addr;
  assign unused_addr = ^{addr_mem[AWIDTH-1:IdxW+2], addr_mem[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    ready_d    = ready_memory;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_mem;
    mem_we     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = misalign_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (read_mem_enable || write_mem_enable) begin
          idx_d      = addr_mem[IdxW+1:2];
          wdata_d    = wdata_mem;
          is_write_d = write_mem_enable;
          cnt_d      = CntW'(LATENCY - 1);
          ready_d    = 1'b0;
          state_d    = StBusy;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_d = |addr_mem[1:0];
`endif
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          ready_d = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          if (misalign_q) begin
            err_d = 1'b1;
          end else
`endif
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      ready_memory <= 1'b1;
      rvalid_mem   <= 1'b0;
      rdata_mem    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
      err_mem      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      ready_memory <= ready_d;
      rvalid_mem   <= rvalid_d;
      rdata_mem    <= rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q   <= misalign_d;
      err_mem      <= err_d;
`endif
    end
  end

  // Array contents are deliberately not reset. A reset mid-operation returns
  // the FSM to idle, so mem_we can never fire for the discarded op.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder (default parameters).
// A reference model tracks block contents by (addr / 4) mod 256 and the
// expected read data register; random and directed operations are compared.
module tb_main_memory_responder;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr_mem = '0;
  logic        read_mem_enable = 1'b0;
  logic        write_mem_enable = 1'b0;
  logic [31:0] wdata_mem = '0;
  logic [31:0] rdata_mem;
  logic        ready_memory;
  logic        rvalid_mem;
  logic        err_mem;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] ref_rdata;

  always #5 clock = ~clock;

  main_memory_responder dut (
    .clock            (clock),
    .reset            (reset),
    .addr_mem         (addr_mem),
    .read_mem_enable  (read_mem_enable),
    .write_mem_enable (write_mem_enable),
    .wdata_mem        (wdata_mem),
    .rdata_mem        (rdata_mem),
    .ready_memory     (ready_memory),
    .rvalid_mem       (rvalid_mem)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .err_mem          (err_mem)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign err_mem = 1'b0;
`endif

  function automatic int blk(input logic [15:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  function automatic bit misaligned(input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (int'(a) % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour of one completed operation.
  function automatic void model_op(input bit rd, input bit wr, input logic [15:0] a,
                                   input logic [31:0] d, output int e_rv, output int e_err);
    e_rv  = 0;
    e_err = 0;
    if (misaligned(a)) begin
      e_err = 1;
    end else if (wr) begin
      ref_mem[blk(a)] = d;
    end else if (rd) begin
      e_rv      = 1;
      ref_rdata = ref_mem[blk(a)];
    end
  endfunction

  // Issue one request once ready, then observe LAT+1 edges after the accept.
  task automatic run_op(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d,
                        output int ready_rise, output int rv_cnt, output int rv_at,
                        output logic [31:0] rv_data, output int err_cnt, output int err_at);
    int w;
    w = 0;
    while (ready_memory !== 1'b1 && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    if (ready_memory !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait got %b want 1", ready_memory);
    end
    addr_mem = a;
    wdata_mem = d;
    read_mem_enable = rd;
    write_mem_enable = wr;
    @(posedge clock); #1;
    read_mem_enable = 1'b0;
    write_mem_enable = 1'b0;
    addr_mem = 16'($urandom);
    wdata_mem = $urandom;
    ready_rise = (ready_memory !== 1'b0) ? 0 : -1;
    rv_cnt = 0;
    rv_at = -1;
    rv_data = 'x;
    err_cnt = 0;
    err_at = -1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clock); #1;
      if (ready_memory === 1'b1 && ready_rise < 0) ready_rise = k;
      if (rvalid_mem === 1'b1) begin
        rv_cnt++;
        rv_at = k;
        rv_data = rdata_mem;
      end
      if (err_mem === 1'b1) begin
        err_cnt++;
        err_at = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (ready_memory !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_memory); end
    checks++;
    if (rvalid_mem !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid_mem); end
    checks++;
    if (rdata_mem !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata_mem); end
    checks++;
    if (err_mem !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_mem); end
    @(negedge clock);
    reset = 1'b1;
    ref_rdata = 32'h0;
    @(posedge clock); #1;
    checks++;
    if (ready_memory !== 1'b1 || rdata_mem !== 32'h0) begin
      errors++;
      $display("FAIL post_rst got ready=%b rdata=%h want ready=1 rdata=0", ready_memory, rdata_mem);
    end
  endtask

  task automatic test_write_read();
    int rr, rc, ra, ec, ea, erv, eer;
    logic [31:0] rd;
    run_op(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, rr, rc, ra, rd, ec, ea);
    model_op(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, erv, eer);
    checks++;
    if (rr !== LAT) begin errors++; $display("FAIL wr_ready_rise got %0d want %0d", rr, LAT); end
    checks++;
    if (rc !== 0) begin errors++; $display("FAIL wr_no_rvalid got %0d want 0", rc); end
    run_op(1'b1, 1'b0, 16'h0010, 32'h0, rr, rc, ra, rd, ec, ea);
    model_op(1'b1, 1'b0, 16'h0010, 32'h0, erv, eer);
    checks++;
    if (rc !== 1 || ra !== LAT) begin
      errors++;
      $display("FAIL rd_rvalid got count=%0d at=%0d want count=1 at=%0d", rc, ra, LAT);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd); end
    checks++;
    if (rr !== LAT) begin errors++; $display("FAIL rd_ready_rise got %0d want %0d", rr, LAT); end
  endtask

  task automatic test_collision();
    int rr, rc, ra, ec, ea, erv, eer;
    logic [31:0] rd;
    run_op(1'b1, 1'b1, 16'h0020, 32'h12345678, rr, rc, ra, rd, ec, ea);
    model_op(1'b1, 1'b1, 16'h0020, 32'h12345678, erv, eer);
    checks++;
    if (rc !== 0) begin errors++; $display("FAIL coll_no_rvalid got %0d want 0", rc); end
    checks++;
    if (rdata_mem !== ref_rdata) begin
      errors++;
      $display("FAIL coll_rdata_hold got %h want %h", rdata_mem, ref_rdata);
    end
    run_op(1'b1, 1'b0, 16'h0020, 32'h0, rr, rc, ra, rd, ec, ea);
    model_op(1'b1, 1'b0, 16'h0020, 32'h0, erv, eer);
    checks++;
    if (rc !== 1 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL coll_read got count=%0d data=%h want 1 12345678", rc, rd);
    end
  endtask

  task automatic test_busy_ignore_alias();
    int rr, rc, ra, ec, ea, erv, eer, pulses;
    logic [31:0] rd, seen;
    run_op(1'b0, 1'b1, 16'h0004, 32'hA5A5A5A5, rr, rc, ra, rd, ec, ea);
    model_op(1'b0, 1'b1, 16'h0004, 32'hA5A5A5A5, erv, eer);
    addr_mem = 16'h0004;
    read_mem_enable = 1'b1;
    @(posedge clock); #1;
    read_mem_enable = 1'b0;
    pulses = 0;
    seen = 'x;
    for (int k = 1; k <= LAT + 4; k++) begin
      if (k == 2) begin
        addr_mem = 16'h0020;
        read_mem_enable = 1'b1;
      end
      if (k == 3) read_mem_enable = 1'b0;
      @(posedge clock); #1;
      if (rvalid_mem === 1'b1) begin
        pulses++;
        seen = rdata_mem;
      end
    end
    model_op(1'b1, 1'b0, 16'h0004, 32'h0, erv, eer);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL busy_ignore pulses got %0d want 1", pulses); end
    checks++;
    if (seen !== 32'hA5A5A5A5) begin errors++; $display("FAIL busy_read got %h want a5a5a5a5", seen); end
    checks++;
    if (ready_memory !== 1'b1) begin errors++; $display("FAIL busy_ready got %b want 1", ready_memory); end
    run_op(1'b1, 1'b0, 16'h0404, 32'h0, rr, rc, ra, rd, ec, ea);
    model_op(1'b1, 1'b0, 16'h0404, 32'h0, erv, eer);
    checks++;
    if (rc !== 1 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL alias_read got count=%0d data=%h want 1 a5a5a5a5", rc, rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int rr, rc, ra, ec, ea, erv, eer;
    logic [31:0] rd;
    run_op(1'b0, 1'b1, 16'h0030, 32'h11111111, rr, rc, ra, rd, ec, ea);
    model_op(1'b0, 1'b1, 16'h0030, 32'h11111111, erv, eer);
    addr_mem = 16'h0030;
    wdata_mem = 32'h22222222;
    write_mem_enable = 1'b1;
    @(posedge clock); #1;
    write_mem_enable = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_rdata = 32'h0;
    #2;
    checks++;
    if (ready_memory !== 1'b1 || rvalid_mem !== 1'b0 || rdata_mem !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst got ready=%b rvalid=%b rdata=%h want 1 0 0",
               ready_memory, rvalid_mem, rdata_mem);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    run_op(1'b1, 1'b0, 16'h0030, 32'h0, rr, rc, ra, rd, ec, ea);
    model_op(1'b1, 1'b0, 16'h0030, 32'h0, erv, eer);
    checks++;
    if (rc !== 1 || rd !== 32'h11111111) begin
      errors++;
      $display("FAIL mid_rst_read got count=%0d data=%h want 1 11111111", rc, rd);
    end
  endtask

  // Read held high across a write: dropped while busy, accepted right after.
  task automatic test_back_to_back();
    int erv, eer, pulses, at;
    logic [31:0] d, seen;
    d = $urandom;
    addr_mem = 16'h0040;
    wdata_mem = d;
    write_mem_enable = 1'b1;
    @(posedge clock); #1;
    write_mem_enable = 1'b0;
    read_mem_enable = 1'b1;
    model_op(1'b0, 1'b1, 16'h0040, d, erv, eer);
    pulses = 0;
    at = -1;
    seen = 'x;
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      @(posedge clock); #1;
      if (k == LAT) begin
        checks++;
        if (ready_memory !== 1'b1) begin errors++; $display("FAIL b2b_ready_hi got %b want 1", ready_memory); end
      end
      if (k == LAT + 1) begin
        read_mem_enable = 1'b0;
        checks++;
        if (ready_memory !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b want 0", ready_memory); end
      end
      if (rvalid_mem === 1'b1) begin
        pulses++;
        at = k;
        seen = rdata_mem;
      end
    end
    model_op(1'b1, 1'b0, 16'h0040, 32'h0, erv, eer);
    checks++;
    if (pulses !== 1 || at !== 2 * LAT + 1) begin
      errors++;
      $display("FAIL b2b_rvalid got count=%0d at=%0d want 1 at %0d", pulses, at, 2 * LAT + 1);
    end
    checks++;
    if (seen !== ref_rdata) begin errors++; $display("FAIL b2b_data got %h want %h", seen, ref_rdata); end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    int rr, rc, ra, ec, ea, erv, eer;
    logic [31:0] rd, before;
    before = rdata_mem;
    run_op(1'b0, 1'b1, 16'h0011, 32'hFFFFFFFF, rr, rc, ra, rd, ec, ea);
    model_op(1'b0, 1'b1, 16'h0011, 32'hFFFFFFFF, erv, eer);
    checks++;
    if (ec !== 1 || ea !== LAT) begin
      errors++;
      $display("FAIL align_err got count=%0d at=%0d want 1 at %0d", ec, ea, LAT);
    end
    checks++;
    if (rc !== 0 || rdata_mem !== before) begin
      errors++;
      $display("FAIL align_side got rvalid=%0d rdata=%h want 0 %h", rc, rdata_mem, before);
    end
    run_op(1'b1, 1'b0, 16'h0010, 32'h0, rr, rc, ra, rd, ec, ea);
    model_op(1'b1, 1'b0, 16'h0010, 32'h0, erv, eer);
    checks++;
    if (rd !== 32'hDEADBEEF || ec !== 0) begin
      errors++;
      $display("FAIL align_prior got %h err=%0d want deadbeef 0", rd, ec);
    end
  endtask
`endif

  task automatic test_random();
    int rr, rc, ra, ec, ea, erv, eer, op;
    logic [31:0] rd, d;
    logic [15:0] a;
    bit r, w;
    for (int j = 0; j < 16; j++) begin
      a = 16'((100 + j) * 4);
      d = $urandom;
      run_op(1'b0, 1'b1, a, d, rr, rc, ra, rd, ec, ea);
      model_op(1'b0, 1'b1, a, d, erv, eer);
    end
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 3));
      r = (op == 0 || op == 2 || op == 3);
      w = (op == 1 || op == 2);
      a = 16'($urandom_range(0, 63) * 1024 + (100 + $urandom_range(0, 15)) * 4);
      if ($urandom_range(0, 4) == 0) a = a + 16'($urandom_range(1, 3));
      d = $urandom;
      run_op(r, w, a, d, rr, rc, ra, rd, ec, ea);
      model_op(r, w, a, d, erv, eer);
      checks++;
      if (rr !== LAT) begin errors++; $display("FAIL rnd_ready op%0d got %0d want %0d", n, rr, LAT); end
      checks++;
      if (rc !== erv || ec !== eer) begin
        errors++;
        $display("FAIL rnd_pulses op%0d got rv=%0d err=%0d want %0d %0d", n, rc, ec, erv, eer);
      end
      checks++;
      if (rdata_mem !== ref_rdata) begin
        errors++;
        $display("FAIL rnd_rdata op%0d addr=%h got %h want %h", n, a, rdata_mem, ref_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_busy_ignore_alias();
    test_reset_mid_op();
    test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
